// File: rtl/bit_unpacker.sv
// bit_unpacker: unpacks 40-bit MSB-first words into a left-aligned bit buffer with a 16-bit peek window
module bit_unpacker #(
    parameter int IN_W    = 40,
    parameter int BUF_W   = 64,
    parameter int MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [MAX_LEN-1:0] peek_data,
    output logic [6:0]         bit_count,
    input  logic               cons_en,
    input  logic [4:0]         cons_len,
    output logic               err
);
    localparam logic [6:0] MAX_L   = 7'(MAX_LEN);
    localparam logic [6:0] IN_L    = 7'(IN_W);
    localparam logic [6:0] RDY_LIM = 7'(BUF_W - IN_W);

    logic [BUF_W-1:0] bits_q, bits_d, shifted, word_ext;
    logic [6:0]       cnt_q, cnt_d, c_after, len;
    logic             err_q, err_d, legal, accept;

    assign in_ready  = !clear && (cnt_q <= RDY_LIM);
    assign peek_data = bits_q[BUF_W-1 -: MAX_LEN];
    assign bit_count = cnt_q;
    assign err       = err_q;

    // consume first, then append an accepted word behind the remaining bits
    always_comb begin
        len      = {2'b00, cons_len};
        accept   = in_valid && in_ready;
        legal    = cons_en && (len <= cnt_q) && (len <= MAX_L);
        shifted  = legal ? bits_q << len : bits_q;
        c_after  = legal ? cnt_q - len : cnt_q;
        word_ext = {in_data, {(BUF_W-IN_W){1'b0}}} >> c_after;
        bits_d   = clear ? '0 : accept ? (shifted | word_ext) : shifted;
        cnt_d    = clear ? '0 : accept ? c_after + IN_L : c_after;
        err_d    = clear ? 1'b0 : (err_q || (cons_en && !legal));
    end

    // buffer, count and sticky error state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bits_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_bit_unpacker.sv
// tb_bit_unpacker: scoreboard bench comparing the unpacker against a bit-queue reference
module tb_bit_unpacker;
    logic        clk = 0;
    logic        reset = 1;
    logic        clear = 0;
    logic [39:0] in_data = '0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] peek_data;
    logic [6:0]  bit_count;
    logic        cons_en = 0;
    logic [4:0]  cons_len = '0;
    logic        err;

    typedef struct {
        logic [15:0] peek;
        logic [6:0]  cnt;
        logic        err;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    bit   mq[$];
    bit   merr = 0;
    int   words = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [39:0] W0 = 40'h0886_4298_E8;

    bit_unpacker dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .peek_data(peek_data), .bit_count(bit_count),
        .cons_en(cons_en), .cons_len(cons_len), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, x);
        end
    endtask

    // monitor: every registered update is compared against the reference snapshot
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("mon_peek", 64'(peek_data), 64'(e_mon.peek));
            chk("mon_count", 64'(bit_count), 64'(e_mon.cnt));
            chk("mon_err", 64'(err), 64'(e_mon.err));
            chk("mon_ready", 64'(in_ready), 64'(e_mon.rdy));
        end
    end

    task automatic step(input logic v, input logic [39:0] w, input logic ce,
                        input logic [4:0] cl, input logic clr);
        exp_t e;
        bit   rdy;
        @(negedge clk);
        #1;
        in_valid = v; in_data = w; cons_en = ce; cons_len = cl; clear = clr;
        rdy = !clr && mq.size() <= 24;
        if (clr) begin
            mq.delete();
            merr = 0;
        end else begin
            if (ce) begin
                if (int'(cl) <= mq.size() && cl <= 16) repeat (cl) void'(mq.pop_front());
                else merr = 1;
            end
            if (v && rdy) begin
                for (int i = 39; i >= 0; i--) mq.push_back(w[i]);
                words++;
            end
        end
        e.peek = '0;
        for (int i = 0; i < 16; i++) if (i < mq.size()) e.peek[15-i] = mq[i];
        e.cnt = 7'(mq.size());
        e.err = merr;
        e.rdy = !clr && mq.size() <= 24;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [39:0] w2;
        int target, guard;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_peek", 64'(peek_data), 0);
        chk("rst_count", 64'(bit_count), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_ready", 64'(in_ready), 1);
        @(negedge clk);
        #1 reset = 0;

        step(1, W0, 0, 0, 0);
        chk("load_peek", 64'(peek_data), 64'h0886);
        chk("load_count", 64'(bit_count), 40);
        chk("load_ready", 64'(in_ready), 0);
        for (int k = 1; k <= 8; k++) begin
            chk("field", 64'(peek_data[15:11]), 64'(k));
            step(0, '0, 1, 5, 0);
        end
        chk("drain_count", 64'(bit_count), 0);
        chk("drain_peek", 64'(peek_data), 0);

        step(1, W0, 0, 0, 0);
        step(0, '0, 1, 5, 0);
        chk("c5_peek", 64'(peek_data), 64'h10C8);
        chk("c5_count", 64'(bit_count), 35);
        step(0, '0, 1, 11, 0);
        chk("c24_count", 64'(bit_count), 24);
        chk("c24_ready", 64'(in_ready), 1);

        w2 = {$urandom, 8'($urandom)};
        step(1, w2, 1, 16, 0);
        chk("both_count", 64'(bit_count), 48);
        chk("both_peek", 64'(peek_data), 64'({8'hE8, w2[39:32]}));

        step(0, '0, 1, 16, 0);
        step(0, '0, 1, 16, 0);
        step(0, '0, 1, 13, 0);
        chk("c3_count", 64'(bit_count), 3);
        step(0, '0, 1, 4, 0);
        chk("ill_err", 64'(err), 1);
        chk("ill_count", 64'(bit_count), 3);
        step(0, '0, 1, 3, 0);
        chk("after_ill_count", 64'(bit_count), 0);
        chk("sticky_err", 64'(err), 1);
        step(0, '0, 0, 0, 1);
        chk("clear_err", 64'(err), 0);
        step(0, '0, 1, 0, 0);
        chk("empty_zero_err", 64'(err), 0);
        step(0, '0, 1, 1, 0);
        chk("empty_one_err", 64'(err), 1);
        step(0, '0, 0, 0, 1);

        step(1, {$urandom, 8'($urandom)}, 0, 0, 0);
        step(0, '0, 1, 15, 0);
        chk("c25_ready", 64'(in_ready), 0);
        step(1, {$urandom, 8'($urandom)}, 1, 16, 0);
        chk("c25_noload", 64'(bit_count), 9);
        step(0, '0, 0, 0, 1);

        target = words + 10;
        guard = 0;
        while (words < target && guard < 3000) begin
            step(1'($urandom_range(0, 1)), {$urandom, 8'($urandom)},
                 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 17)), 1'($urandom_range(0, 60) == 0));
            guard++;
        end
        chk("stream_words_within_budget", 64'(words >= target), 1);

        step(0, '0, 0, 0, 1);
        step(1, {$urandom, 8'($urandom)}, 0, 0, 0);
        step(0, '0, 1, 3, 0);
        chk("pre_reset_count", 64'(bit_count), 37);
        @(negedge clk);
        #2;
        reset = 1; in_valid = 0; cons_en = 0; clear = 0;
        #1;
        chk("async_peek", 64'(peek_data), 0);
        chk("async_count", 64'(bit_count), 0);
        chk("async_ready", 64'(in_ready), 1);
        mq.delete();
        merr = 0;
        @(negedge clk);
        #1 reset = 0;
        step(1, W0, 0, 0, 0);
        chk("fresh_peek", 64'(peek_data), 64'h0886);
        chk("fresh_count", 64'(bit_count), 40);

        @(negedge clk);
        #1;
        in_valid = 0; cons_en = 0; clear = 0;
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bit_unpacker.md
# bit_unpacker

Bitstream unpacker for the JPEG datapath, the read-side counterpart of the 5-bit field packer that builds 40-bit words. It accepts 40-bit packed words MSB-first through a valid/ready handshake and holds them in a 64-bit left-aligned bit buffer. The downstream consumer (Huffman/field decoder) sees the next 16 unread bits and removes 0..16 bits per cycle. It sits between the word FIFO/memory reader and the symbol decoder.

## Interface
- IN_W, 40, packed input word width (bits consumed MSB-first)
- BUF_W, 64, bit buffer width; must be ≥ IN_W + MAX_LEN + 8
- MAX_LEN, 16, peek window and largest legal consume length
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- clear  input  1  synchronous flush; discards buffer, clears count and err
- in_data  input  IN_W  packed word; bit IN_W-1 is the oldest bit
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- peek_data  output  MAX_LEN  next MAX_LEN unread bits, oldest at MSB; unfilled positions read 0
- bit_count  output  7  number of unread bits held (0..BUF_W)
- cons_en  input  1  consume request this cycle
- cons_len  input  5  bits to consume (0..MAX_LEN)
- err  output  1  sticky illegal-consume flag

## Operation
- State: buf[BUF_W-1:0] (unread bits left-aligned at bit BUF_W-1, all bits below the data are 0), cnt[6:0], err.
- in_ready = !clear && (cnt ≤ BUF_W-IN_W), i.e. cnt ≤ 24. Purely combinational from registered cnt and clear. Word accepted when in_valid && in_ready.
- Consume legal iff cons_en && cons_len ≤ cnt && cons_len ≤ MAX_LEN. Legal consume of length L: buf ← buf << L; cnt ← cnt − L. L=0 is a legal no-op.
- Illegal consume: buf and cnt unchanged by the consume, err ← 1. A simultaneous accepted word still loads.
- Load of word W after consume: W is OR-ed into buf at bits [BUF_W-1-c' -: IN_W], where c' = cnt after consume. cnt ← c' + IN_W. This cannot overflow because cnt ≤ 24 at accept.
- Simultaneous consume and load in one cycle is fully supported. The consume is applied first, then the load appends behind the remaining bits.
- peek_data = buf[BUF_W-1 -: MAX_LEN], driven directly from the register with no extra logic.
- clear: buf ← 0, cnt ← 0, err ← 0. Input is not accepted and consume is ignored that cycle. Clear has priority over everything except reset.
- All arithmetic is unsigned. Shift amounts are 0..16; insertion offset is 0..24.

## Timing
- Reset values: buf=0, cnt=0, err=0, peek_data=0, bit_count=0, in_ready=1.
- Reset asserted mid-operation discards all buffered bits immediately (asynchronous). in_ready returns to 1 while reset is held.
- Accept at edge t: word bits are visible in peek_data/bit_count from t+1.
- Consume at edge t: peek_data shows the shifted window from t+1. The consumer may issue back-to-back consumes every cycle using the updated bit_count.
- Empty (cnt=0): any cons_len>0 is illegal and sets err. cons_len=0 is allowed.
- Full-side boundary: cnt=24 gives in_ready=1. cnt=25 gives in_ready=0 even if a consume is requested the same cycle. Readiness uses registered cnt only.
- err stays 1 until reset or clear.

## Test plan
- Reset, then load in_data=40'h0886_4298_E8 → t+1: bit_count=40, peek_data=16'h0886, in_ready=0. Consume 5 ×8 over consecutive cycles → top 5 bits read 1,2,3,…,8 in order. Final bit_count=0, peek_data=0.
- Same word loaded, consume 5 once → peek_data=16'h10C8, bit_count=35. Consume 11 → bit_count=24, in_ready=1.
- With cnt=24, assert in_valid and cons_len=16 in the same cycle → next cnt=48. The 8 remaining old bits are followed directly by the new word's 40 bits in peek_data.
- With cnt=3, issue cons_len=4 → err=1, cnt stays 3, peek_data unchanged. Then cons_len=3 → cnt=0, err stays 1. Assert clear → err=0.
- Stream 10 random words while randomly consuming 0..16 bits per cycle against a reference bit queue. Expect peek_data/bit_count to match every cycle, with no word accepted while cnt>24.
- Assert reset asynchronously mid-stream with cnt=37 → outputs read 0 and in_ready=1 before the next edge. Deassert reset, and a fresh word loads correctly.
